// File: rtl/stack_address_sequencer_pkg.sv
// Shared types for the stack address sequencer: op codes, FSM states,
// and region bound helpers. No ports.
package stack_address_pkg;

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_PUSH   = 3'd1;
  localparam logic [2:0] OP_POP    = 3'd2;
  localparam logic [2:0] OP_SET_SP = 3'd3;
  localparam logic [2:0] OP_BL     = 3'd4;
  localparam logic [2:0] OP_BRANCH = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH_BEAT,
    S_POP_BEAT
  } state_t;

  // Lowest address of a mode's region (the "full" SP value).
  function automatic logic [63:0] region_top(
    input int unsigned mode,
    input int unsigned base,
    input int unsigned size
  );
    return 64'(base) + 64'(mode) * 64'(size);
  endfunction

  // Highest address of a mode's region; empty SP is this plus one.
  function automatic logic [63:0] region_bottom(
    input int unsigned mode,
    input int unsigned base,
    input int unsigned size
  );
    return region_top(mode + 1, base, size) - 64'd1;
  endfunction

endpackage

// File: rtl/stack_address_sequencer_if.sv
// Op and memory-beat bundle between core and sequencer.
// master = core side (drives ops, mem_ready), slave = sequencer.
interface stack_address_sequencer_if #(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_MODES      = 2,
  parameter int REG_LIST_WIDTH = 8
);
  localparam int MW =
    (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int RW =
    (REG_LIST_WIDTH > 1) ? $clog2(REG_LIST_WIDTH) : 1;

  logic [MW-1:0]             mode;
  logic [2:0]                op;
  logic                      op_valid;
  logic                      op_ready;
  logic [REG_LIST_WIDTH-1:0] reg_list;
  logic                      should_branch;
  logic [WORD_SIZE-1:0]      ALU_result;
  logic                      fault_clear;
  logic                      mem_valid;
  logic                      mem_ready;
  logic                      mem_write;
  logic [WORD_SIZE-1:0]      mem_address;
  logic [RW-1:0]             reg_index;
  logic [WORD_SIZE-1:0]      instruction_address;
  logic [WORD_SIZE-1:0]      current_SP;
  logic [WORD_SIZE-1:0]      link_value;
  logic                      fault_overflow;
  logic                      fault_underflow;

  modport master (
    output mode, op, op_valid, reg_list,
    output should_branch, ALU_result,
    output fault_clear, mem_ready,
    input  op_ready, mem_valid, mem_write,
    input  mem_address, reg_index,
    input  instruction_address, current_SP,
    input  link_value,
    input  fault_overflow, fault_underflow
  );

  modport slave (
    input  mode, op, op_valid, reg_list,
    input  should_branch, ALU_result,
    input  fault_clear, mem_ready,
    output op_ready, mem_valid, mem_write,
    output mem_address, reg_index,
    output instruction_address, current_SP,
    output link_value,
    output fault_overflow, fault_underflow
  );

endinterface

// File: rtl/stack_pointer_bank.sv
// Banked stack pointers, one per mode, with region decode and one
// write port (sel + inc/dec/load). Ports: i_clk, i_rst, i_sel,
// i_inc, i_dec, i_load, i_load_val, o_sp, o_top, o_bottom,
// o_full, o_empty.
module stack_pointer_bank
  import stack_address_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_MODES  = 2,
  parameter int STACK_BASE = 4096,
  parameter int STACK_SIZE = 2048,
  parameter int MW =
    (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [MW-1:0]        i_sel,
  input  logic                 i_inc,
  input  logic                 i_dec,
  input  logic                 i_load,
  input  logic [WORD_SIZE-1:0] i_load_val,
  output logic [NUM_MODES-1:0][WORD_SIZE-1:0] o_sp,
  output logic [NUM_MODES-1:0][WORD_SIZE-1:0] o_top,
  output logic [NUM_MODES-1:0][WORD_SIZE-1:0] o_bottom,
  output logic [NUM_MODES-1:0] o_full,
  output logic [NUM_MODES-1:0] o_empty
);

  logic [NUM_MODES-1:0][WORD_SIZE-1:0] r_sp;
  logic [NUM_MODES-1:0][WORD_SIZE-1:0] w_empty_val;

  always_comb begin
    o_top       = '0;
    o_bottom    = '0;
    w_empty_val = '0;
    o_full      = '0;
    o_empty     = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      o_top[m] = WORD_SIZE'(
        region_top(m, STACK_BASE, STACK_SIZE));
      o_bottom[m] = WORD_SIZE'(
        region_bottom(m, STACK_BASE, STACK_SIZE));
      w_empty_val[m] = o_bottom[m] + WORD_SIZE'(1);
      o_full[m]  = (r_sp[m] == o_top[m]);
      o_empty[m] = (r_sp[m] == w_empty_val[m]);
    end
  end

  assign o_sp = r_sp;

  always_ff @(posedge i_clk) begin
    for (int m = 0; m < NUM_MODES; m++) begin
      if (i_rst) begin
        r_sp[m] <= w_empty_val[m];
      end else if (MW'(m) == i_sel) begin
        unique case (1'b1)
          i_load:  r_sp[m] <= i_load_val;
          i_inc:   r_sp[m] <= r_sp[m] + WORD_SIZE'(1);
          i_dec:   r_sp[m] <= r_sp[m] - WORD_SIZE'(1);
          default: r_sp[m] <= r_sp[m];
        endcase
      end
    end
  end

endmodule

// File: rtl/stack_address_sequencer.sv
// PC, banked SP and PUSH/POP list sequencer, one beat per cycle.
// Ports: clock, reset, bus (slave side of the op/memory bundle).
module stack_address_sequencer
  import stack_address_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_MODES      = 2,
  parameter int STACK_BASE     = 4096,
  parameter int STACK_SIZE     = 2048,
  parameter int REG_LIST_WIDTH = 8,
  parameter int PC_RESET       = 0
) (
  input logic clock,
  input logic reset,
  stack_address_sequencer_if.slave bus
);

  localparam int MW =
    (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int RW =
    (REG_LIST_WIDTH > 1) ? $clog2(REG_LIST_WIDTH) : 1;
  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  state_t r_state, w_next;
  logic [WORD_SIZE-1:0] r_pc, r_link;
  logic [REG_LIST_WIDTH-1:0] r_list, w_list_clr;
  logic [MW-1:0] r_mode, w_sel;
  logic r_fovf, r_funf;

  logic [NUM_MODES-1:0][WORD_SIZE-1:0] w_sp_all;
  logic [NUM_MODES-1:0][WORD_SIZE-1:0] w_top_all;
  logic [NUM_MODES-1:0][WORD_SIZE-1:0] w_bot_all;
  logic [NUM_MODES-1:0] w_full_all, w_empty_all;

  logic [WORD_SIZE-1:0] w_sp, w_top, w_empty_val;
  logic w_full, w_empty;
  logic [RW-1:0] w_hi, w_lo, w_idx;
  logic w_idle, w_push, w_pop, w_ready;
  logic w_accept, w_list_op, w_setsp;
  logic w_below, w_above;
  logic w_mem_valid, w_beat, w_last, w_fault_beat;
  logic w_inc, w_dec, w_load;
  logic w_set_ovf, w_set_unf, w_taken;

  assign w_idle = (r_state == S_IDLE);
  assign w_push = (r_state == S_PUSH_BEAT);
  assign w_pop  = (r_state == S_POP_BEAT);
  assign w_ready = w_idle && !reset;

  // The burst keeps using the mode latched at accept.
  assign w_sel = w_idle ? bus.mode : r_mode;

  assign w_sp        = w_sp_all[w_sel];
  assign w_top       = w_top_all[w_sel];
  assign w_empty_val = w_bot_all[w_sel] + ONE;
  assign w_full      = w_full_all[w_sel];
  assign w_empty     = w_empty_all[w_sel];

  assign w_accept  = bus.op_valid && w_ready;
  assign w_list_op = ((bus.op == OP_PUSH) ||
                      (bus.op == OP_POP)) &&
                     (|bus.reg_list);
  assign w_setsp = w_accept && (bus.op == OP_SET_SP);
  assign w_below = bus.ALU_result < w_top;
  assign w_above = bus.ALU_result > w_empty_val;
  assign w_taken = bus.should_branch &&
                   ((bus.op == OP_BL) ||
                    (bus.op == OP_BRANCH));

  // PUSH serves the highest index first, POP the lowest.
  always_comb begin
    w_hi = '0;
    w_lo = '0;
    for (int i = 0; i < REG_LIST_WIDTH; i++)
      if (r_list[i]) w_hi = RW'(i);
    for (int i = REG_LIST_WIDTH - 1; i >= 0; i--)
      if (r_list[i]) w_lo = RW'(i);
  end

  assign w_idx = w_push ? w_hi : w_lo;
  assign w_list_clr =
    r_list & ~(REG_LIST_WIDTH'(1) << w_idx);

  // A beat that would cross the region edge is never issued.
  assign w_fault_beat = (w_push && w_full) ||
                        (w_pop && w_empty);
  assign w_mem_valid = (w_push && !w_full) ||
                       (w_pop && !w_empty);
  assign w_beat = w_mem_valid && bus.mem_ready;
  assign w_last = w_beat && (w_list_clr == '0);

  assign w_inc  = w_pop && w_beat;
  assign w_dec  = w_push && w_beat;
  assign w_load = w_setsp && !w_below && !w_above;

  assign w_set_ovf = (w_setsp && w_below) ||
                     (w_push && w_full);
  assign w_set_unf = (w_setsp && w_above) ||
                     (w_pop && w_empty);

  stack_pointer_bank #(
    .WORD_SIZE  (WORD_SIZE),
    .NUM_MODES  (NUM_MODES),
    .STACK_BASE (STACK_BASE),
    .STACK_SIZE (STACK_SIZE),
    .MW         (MW)
  ) u_bank (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_sel      (w_sel),
    .i_inc      (w_inc),
    .i_dec      (w_dec),
    .i_load     (w_load),
    .i_load_val (bus.ALU_result),
    .o_sp       (w_sp_all),
    .o_top      (w_top_all),
    .o_bottom   (w_bot_all),
    .o_full     (w_full_all),
    .o_empty    (w_empty_all)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_list_op)
          w_next = (bus.op == OP_PUSH) ?
                   S_PUSH_BEAT : S_POP_BEAT;
      end
      S_PUSH_BEAT, S_POP_BEAT: begin
        if (w_fault_beat || w_last)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.op_ready  = w_ready;
    bus.mem_valid = w_mem_valid;
    bus.mem_write = w_push;
    bus.reg_index = w_idx;
    bus.mem_address = bus.ALU_result;
    unique case (r_state)
      S_PUSH_BEAT: bus.mem_address = w_sp - ONE;
      S_POP_BEAT:  bus.mem_address = w_sp;
      default:     bus.mem_address = bus.ALU_result;
    endcase
    bus.instruction_address = r_pc;
    bus.current_SP      = w_sp;
    bus.link_value      = r_link;
    bus.fault_overflow  = r_fovf;
    bus.fault_underflow = r_funf;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc   <= WORD_SIZE'(PC_RESET);
      r_link <= '0;
      r_list <= '0;
      r_mode <= '0;
      r_fovf <= 1'b0;
      r_funf <= 1'b0;
    end else begin
      if (w_accept && !w_list_op) begin
        r_pc <= w_taken ? bus.ALU_result : r_pc + ONE;
        if (bus.op == OP_BL) r_link <= r_pc + ONE;
      end else if (w_fault_beat || w_last) begin
        r_pc <= r_pc + ONE;
      end

      if (w_accept) begin
        r_list <= bus.reg_list;
        r_mode <= bus.mode;
      end else if (w_fault_beat) begin
        r_list <= '0;
      end else if (w_beat) begin
        r_list <= w_list_clr;
      end

      // A new fault beats a simultaneous clear.
      if (w_set_ovf)            r_fovf <= 1'b1;
      else if (bus.fault_clear) r_fovf <= 1'b0;
      if (w_set_unf)            r_funf <= 1'b1;
      else if (bus.fault_clear) r_funf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_address_sequencer.sv
// Bench for stack_address_sequencer: vector table, random ops
// against a list-level model, and a reset-mid-burst sequence.
module tb_stack_address_sequencer;

  localparam int BASE = 4096;
  localparam int SIZE = 2048;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stack_address_sequencer_if #(
    .WORD_SIZE(32), .NUM_MODES(2), .REG_LIST_WIDTH(8)
  ) bus ();

  stack_address_sequencer #(
    .WORD_SIZE(32), .NUM_MODES(2),
    .STACK_BASE(BASE), .STACK_SIZE(SIZE),
    .REG_LIST_WIDTH(8), .PC_RESET(0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    int          idx;
  } beat_t;

  int unsigned m_pc, m_link;
  int unsigned m_sp [2];
  bit          m_ovf, m_unf;
  beat_t       exp_q [$];

  typedef struct {
    int op; int list; int mode;
    int unsigned alu; bit sb; bit clr; int stall;
    int unsigned pc, link, sp0, sp1;
    bit ov, un; int low;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned top_of(input int m);
    return BASE + m * SIZE;
  endfunction

  function automatic int unsigned empty_of(input int m);
    return BASE + (m + 1) * SIZE;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_link = 0;
    m_sp[0] = empty_of(0);
    m_sp[1] = empty_of(1);
    m_ovf = 0; m_unf = 0;
    exp_q.delete();
  endtask

  // Whole-op model: list walk with a stop at the region edge.
  task automatic model_op(input int op, input int list,
                          input int mode,
                          input int unsigned alu,
                          input bit sb, input bit clr);
    bit nv, nu, stop;
    nv = 0; nu = 0; stop = 0;
    exp_q.delete();
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if ((op == 1 || op == 2) && list != 0) begin
      if (op == 1) begin
        for (int i = 7; i >= 0; i--)
          if (!stop && list[i]) begin
            if (m_sp[mode] == top_of(mode)) begin
              nv = 1; stop = 1;
            end else begin
              m_sp[mode] = m_sp[mode] - 1;
              exp_q.push_back(beat_t'{m_sp[mode], i});
            end
          end
      end else begin
        for (int i = 0; i < 8; i++)
          if (!stop && list[i]) begin
            if (m_sp[mode] == empty_of(mode)) begin
              nu = 1; stop = 1;
            end else begin
              exp_q.push_back(beat_t'{m_sp[mode], i});
              m_sp[mode] = m_sp[mode] + 1;
            end
          end
      end
      m_pc = m_pc + 1;
    end else begin
      case (op)
        3: begin
          if (alu < top_of(mode)) nv = 1;
          else if (alu > empty_of(mode)) nu = 1;
          else m_sp[mode] = alu;
          m_pc = m_pc + 1;
        end
        4: begin
          m_link = m_pc + 1;
          m_pc = sb ? alu : m_pc + 1;
        end
        5: m_pc = sb ? alu : m_pc + 1;
        default: m_pc = m_pc + 1;
      endcase
    end
    m_ovf = m_ovf | nv;
    m_unf = m_unf | nu;
  endtask

  task automatic run_op(input int op, input int list,
                        input int mode,
                        input int unsigned alu,
                        input bit sb, input bit clr,
                        input int stall_first,
                        input bit rnd, output int low);
    int beat, waitc, stall;
    logic [31:0] held;
    bit done;
    beat_t e;
    beat = 0; waitc = 0; stall = 0;
    held = '0; done = 0; low = 0;
    model_op(op, list, mode, alu, sb, clr);
    bus.op = 3'(op);
    bus.reg_list = 8'(list);
    bus.mode = 1'(mode);
    bus.ALU_result = alu;
    bus.should_branch = sb;
    bus.fault_clear = clr;
    bus.op_valid = 1'b1;
    @(negedge clock);
    bus.op_valid = 1'b0;
    bus.op = 3'($urandom_range(0, 7));
    bus.mode = 1'($urandom_range(0, 1));
    bus.reg_list = 8'($urandom_range(0, 255));
    while (!done) begin
      if (bus.op_ready) begin
        done = 1;
      end else begin
        low++;
        if (bus.mem_valid) begin
          if (waitc == 0) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL extra_beat: got addr %0d, want none",
                       bus.mem_address);
            end else begin
              e = exp_q.pop_front();
              check("beat_addr", bus.mem_address, e.addr);
              check("beat_reg", 32'(bus.reg_index), e.idx);
              check("beat_write", 32'(bus.mem_write),
                    32'(op == 1));
            end
            held = bus.mem_address;
            stall = (beat == 0) ? stall_first :
                    (rnd ? $urandom_range(0, 2) : 0);
          end else begin
            check("addr_stable", bus.mem_address, held);
          end
          if (waitc < stall) begin
            bus.mem_ready = 1'b0;
            waitc++;
          end else begin
            bus.mem_ready = 1'b1;
            beat++;
            waitc = 0;
          end
        end else begin
          bus.mem_ready = 1'b0;
        end
        if (low > 100) begin
          total++; bad++;
          $display("FAIL timeout: got busy %0d, want <=100", low);
          done = 1;
        end
        if (!done) @(negedge clock);
      end
    end
    bus.mem_ready = 1'b0;
    check("beats_left", exp_q.size(), 0);
  endtask

  task automatic check_state(input string tag,
                             input int unsigned pc,
                             input int unsigned link,
                             input int unsigned sp0,
                             input int unsigned sp1,
                             input bit ov, input bit un);
    bus.fault_clear = 1'b0;
    bus.mode = 1'b0;
    #1;
    check({tag, ".sp0"}, bus.current_SP, sp0);
    bus.mode = 1'b1;
    #1;
    check({tag, ".sp1"}, bus.current_SP, sp1);
    check({tag, ".pc"}, bus.instruction_address, pc);
    check({tag, ".link"}, bus.link_value, link);
    check({tag, ".ovf"}, 32'(bus.fault_overflow), 32'(ov));
    check({tag, ".unf"}, 32'(bus.fault_underflow), 32'(un));
    check({tag, ".rdy"}, 32'(bus.op_ready), 1);
    check({tag, ".mv"}, 32'(bus.mem_valid), 0);
  endtask

  task automatic add(input int op, input int list,
                     input int mode, input int unsigned alu,
                     input bit sb, input bit clr,
                     input int stall, input int unsigned pc,
                     input int unsigned link,
                     input int unsigned sp0,
                     input int unsigned sp1,
                     input bit ov, input bit un,
                     input int low);
    tbl.push_back(vec_t'{op, list, mode, alu, sb, clr,
                         stall, pc, link, sp0, sp1,
                         ov, un, low});
  endtask

  initial begin
    int low;
    int op, list, mode, pick;
    int unsigned alu;

    //  op list  m alu   sb clr st | pc  lk  sp0   sp1  ov un low
    add(0, 0,   0, 0,    0, 0, 0,   1,  0, 6144, 8192, 0, 0, 0);
    add(0, 0,   0, 0,    0, 0, 0,   2,  0, 6144, 8192, 0, 0, 0);
    add(0, 0,   0, 0,    0, 0, 0,   3,  0, 6144, 8192, 0, 0, 0);
    add(1, 5,   0, 0,    0, 0, 2,   4,  0, 6142, 8192, 0, 0, 4);
    add(2, 5,   0, 0,    0, 0, 0,   5,  0, 6144, 8192, 0, 0, 2);
    add(2, 2,   0, 0,    0, 0, 0,   6,  0, 6144, 8192, 0, 1, 1);
    add(0, 0,   0, 0,    0, 1, 0,   7,  0, 6144, 8192, 0, 0, 0);
    add(3, 0,   0, 4097, 0, 0, 0,   8,  0, 4097, 8192, 0, 0, 0);
    add(1, 7,   0, 0,    0, 0, 0,   9,  0, 4096, 8192, 1, 0, 2);
    add(3, 0,   1, 8193, 0, 0, 0,  10,  0, 4096, 8192, 1, 1, 0);
    add(0, 0,   0, 0,    0, 1, 0,  11,  0, 4096, 8192, 0, 0, 0);
    add(3, 0,   1, 6143, 0, 0, 0,  12,  0, 4096, 8192, 1, 0, 0);
    add(3, 0,   1, 6144, 0, 1, 0,  13,  0, 4096, 6144, 0, 0, 0);
    add(1, 1,   1, 0,    0, 1, 0,  14,  0, 4096, 6144, 1, 0, 1);
    add(3, 0,   1, 8192, 0, 1, 0,  15,  0, 4096, 8192, 0, 0, 0);
    add(5, 0,   0, 10,   1, 0, 0,  10,  0, 4096, 8192, 0, 0, 0);
    add(4, 0,   0, 999,  0, 0, 0,  11, 11, 4096, 8192, 0, 0, 0);
    add(5, 0,   0, 10,   1, 0, 0,  10, 11, 4096, 8192, 0, 0, 0);
    add(4, 0,   0, 200,  1, 0, 0, 200, 11, 4096, 8192, 0, 0, 0);
    add(5, 0,   0, 5,    0, 0, 0, 201, 11, 4096, 8192, 0, 0, 0);
    add(7, 0,   0, 0,    0, 0, 0, 202, 11, 4096, 8192, 0, 0, 0);
    add(1, 0,   0, 0,    0, 0, 0, 203, 11, 4096, 8192, 0, 0, 0);

    reset = 1'b1;
    bus.mode = 1'b0;
    bus.op = 3'd0;
    bus.op_valid = 1'b0;
    bus.reg_list = 8'd0;
    bus.should_branch = 1'b0;
    bus.ALU_result = 32'd0;
    bus.fault_clear = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    check_state("reset", 0, 0, 6144, 8192, 0, 0);

    foreach (tbl[k]) begin
      run_op(tbl[k].op, tbl[k].list, tbl[k].mode,
             tbl[k].alu, tbl[k].sb, tbl[k].clr,
             tbl[k].stall, 1'b0, low);
      check_state($sformatf("vec%0d", k), tbl[k].pc,
                  tbl[k].link, tbl[k].sp0, tbl[k].sp1,
                  tbl[k].ov, tbl[k].un);
      check($sformatf("vec%0d.low", k), low, tbl[k].low);
    end

    for (int n = 0; n < 120; n++) begin
      op   = $urandom_range(0, 7);
      mode = $urandom_range(0, 1);
      list = ($urandom_range(0, 4) == 0) ? 0 :
             $urandom_range(1, 255);
      pick = $urandom_range(0, 4);
      case (pick)
        0: alu = top_of(mode) + $urandom_range(0, 3);
        1: alu = empty_of(mode) - $urandom_range(0, 3);
        2: alu = empty_of(mode) + $urandom_range(0, 2);
        3: alu = top_of(mode) - $urandom_range(0, 2);
        default: alu = $urandom;
      endcase
      run_op(op, list, mode, alu,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0),
             $urandom_range(0, 2), 1'b1, low);
      check_state("rnd", m_pc, m_link, m_sp[0], m_sp[1],
                  m_ovf, m_unf);
    end

    run_op(3, 0, 1, 8192, 0, 0, 0, 1'b0, low);
    bus.op = 3'd1;
    bus.reg_list = 8'h0F;
    bus.mode = 1'b1;
    bus.op_valid = 1'b1;
    @(negedge clock);
    bus.op_valid = 1'b0;
    check("rst.beat1", bus.mem_address, 8191);
    bus.mem_ready = 1'b1;
    @(negedge clock);
    check("rst.beat2", bus.mem_address, 8190);
    check("rst.reg2", 32'(bus.reg_index), 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    model_reset();
    check_state("post_rst", 0, 0, 6144, 8192, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
